// File: rtl/dec_error_corrector_8bit.sv
// Extended-Hamming(8,4) error corrector.
// Takes a received codeword together with its syndrome. It flips the bit
// selected by the syndrome for a single error, or flags a double error that
// cannot be corrected. The datapath is a two-stage valid/ready pipeline, and
// two saturating counters keep statistics on delivered results.
module dec_error_corrector_8bit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       codeword_with_errors,
    input  logic [3:0]       syndrome,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       corrected_codeword,
    output logic [3:0]       data_out,
    output logic             err_single,
    output logic             err_double,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_DOUBLE = 2'd2
    } err_class_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Both stages move together. The pipeline holds as a whole while the
    // consumer stalls a valid result.
    logic adv;
    logic out_fire;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_fire = out_valid && out_ready;

    // Stage-1 state
    logic       s1_valid;
    logic [7:0] s1_cw;
    err_class_e s1_class;
    logic [2:0] s1_idx;

    // Syndrome decode: s[3] is the overall-parity mismatch, s[2:0] the bit index
    err_class_e in_class;

    // Classify the incoming syndrome
    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches.
        in_class = CLS_NONE;
        if (syndrome[3]) begin
            in_class = CLS_SINGLE;
        end else if (syndrome[2:0] != 3'd0) begin
            in_class = CLS_DOUBLE;
        end
    end

    // Stage 1: capture the codeword and the decoded class and index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cw    <= '0;
            s1_class <= CLS_NONE;
            s1_idx   <= '0;
        end else if (adv) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples values from before the edge.
            s1_valid <= in_valid;
            s1_cw    <= codeword_with_errors;
            s1_class <= in_class;
            s1_idx   <= syndrome[2:0];
        end
    end

    // Correction: flip the indexed bit for a single error (index 0 flips bit 0)
    logic [7:0] flip_mask;
    logic [7:0] cc_next;

    // Build the corrected codeword from the stage-1 contents
    always_comb begin
        flip_mask = 8'd0;
        if (s1_class == CLS_SINGLE) begin
            flip_mask = 8'd1 << s1_idx;
        end
        cc_next = s1_cw ^ flip_mask;
    end

    // Stage 2: register the result. A bubble zeroes the fields, so no stale
    // data is visible while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid          <= 1'b0;
            corrected_codeword <= '0;
            data_out           <= '0;
            err_single         <= 1'b0;
            err_double         <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                corrected_codeword <= cc_next;
                data_out           <= {cc_next[7], cc_next[6], cc_next[5], cc_next[3]};
                err_single         <= (s1_class == CLS_SINGLE);
                err_double         <= (s1_class == CLS_DOUBLE);
            end else begin
                corrected_codeword <= '0;
                data_out           <= '0;
                err_single         <= 1'b0;
                err_double         <= 1'b0;
            end
        end
    end

    // Statistics: count delivered flagged results, saturate, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clear) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_fire) begin
            if (err_single && corr_cnt != CNT_MAX) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (err_double && uncorr_cnt != CNT_MAX) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dec_error_corrector_8bit.sv
// Directed testbench for dec_error_corrector_8bit.
// Instance dut uses the default counter width. Instance dut2 uses CNT_W=2 for
// the saturation checks. Both instances share the same stimulus.
module tb_dec_error_corrector_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  cw;
    logic [3:0]  s;
    logic        cnt_clear;

    logic        in_ready,   in_ready2;
    logic        out_valid,  out_valid2;
    logic [7:0]  cc,         cc2;
    logic [3:0]  data,       data2;
    logic        es,         es2;
    logic        ed,         ed2;
    logic [15:0] corr,       uncorr;
    logic [1:0]  corr2,      uncorr2;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_corr = 0;
    int exp_uncorr = 0;

    always #5 clk = ~clk;

    dec_error_corrector_8bit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .codeword_with_errors(cw), .syndrome(s), .out_valid(out_valid),
        .out_ready(out_ready), .corrected_codeword(cc), .data_out(data),
        .err_single(es), .err_double(ed), .cnt_clear(cnt_clear),
        .corr_cnt(corr), .uncorr_cnt(uncorr)
    );

    dec_error_corrector_8bit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .codeword_with_errors(cw), .syndrome(s), .out_valid(out_valid2),
        .out_ready(out_ready), .corrected_codeword(cc2), .data_out(data2),
        .err_single(es2), .err_double(ed2), .cnt_clear(cnt_clear),
        .corr_cnt(corr2), .uncorr_cnt(uncorr2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one pair with no backpressure and stop right after out_valid rises
    task automatic drive_one(input logic [7:0] c, input logic [3:0] sy);
        in_valid  = 1'b1;
        cw        = c;
        s         = sy;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
        cw = 8'h00; s = 4'h0;
        repeat (3) step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_checks++; if (cc !== 8'h00) begin n_fail++; $display("FAIL rst_cc got %b want 00000000", cc); end
        n_checks++; if (data !== 4'h0) begin n_fail++; $display("FAIL rst_data got %b want 0000", data); end
        n_checks++; if ({es, ed} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b want 00", {es, ed}); end
        n_checks++; if (corr !== 16'd0 || uncorr !== 16'd0) begin n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", corr, uncorr); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        step();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_ready got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    endtask

    // A single error at index 5 is corrected; checks the latency of exactly 2 cycles
    task automatic test_single;
        in_valid = 1'b1; cw = 8'b10001010; s = 4'b1101; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early got %b want 0", out_valid); end
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got %b want 1", out_valid); end
        n_checks++; if (cc !== 8'b10101010) begin n_fail++; $display("FAIL single_cc got %b want 10101010", cc); end
        n_checks++; if (data !== 4'b1011) begin n_fail++; $display("FAIL single_data got %b want 1011", data); end
        n_checks++; if ({es, ed} !== 2'b10) begin n_fail++; $display("FAIL single_flags got %b want 10", {es, ed}); end
        step();
        exp_corr++;
        n_checks++; if (corr !== 16'(exp_corr)) begin n_fail++; $display("FAIL single_corr_cnt got %0d want %0d", corr, exp_corr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_clean;
        drive_one(8'b10101010, 4'b0000);
        n_checks++; if (cc !== 8'b10101010 || data !== 4'b1011) begin n_fail++; $display("FAIL clean_data got cc=%b d=%b want 10101010/1011", cc, data); end
        n_checks++; if ({es, ed} !== 2'b00) begin n_fail++; $display("FAIL clean_flags got %b want 00", {es, ed}); end
        step();
        n_checks++; if (corr !== 16'(exp_corr) || uncorr !== 16'(exp_uncorr)) begin n_fail++; $display("FAIL clean_counters got %0d/%0d want %0d/%0d", corr, uncorr, exp_corr, exp_uncorr); end
    endtask

    task automatic test_double;
        drive_one(8'b10100010, 4'b0011);
        n_checks++; if (cc !== 8'b10100010 || data !== 4'b1010) begin n_fail++; $display("FAIL double_data got cc=%b d=%b want 10100010/1010", cc, data); end
        n_checks++; if ({es, ed} !== 2'b01) begin n_fail++; $display("FAIL double_flags got %b want 01", {es, ed}); end
        step();
        exp_uncorr++;
        n_checks++; if (uncorr !== 16'(exp_uncorr) || corr !== 16'(exp_corr)) begin n_fail++; $display("FAIL double_counters got %0d/%0d want %0d/%0d", corr, uncorr, exp_corr, exp_uncorr); end
    endtask

    // Index 7 with a parity mismatch corrects the top bit
    task automatic test_bit7;
        drive_one(8'b00000000, 4'b1111);
        n_checks++; if (cc !== 8'b10000000 || data !== 4'b1000) begin n_fail++; $display("FAIL bit7_data got cc=%b d=%b want 10000000/1000", cc, data); end
        n_checks++; if ({es, ed} !== 2'b10) begin n_fail++; $display("FAIL bit7_flags got %b want 10", {es, ed}); end
        step();
        exp_corr++;
    endtask

    // Four pairs stream in; the consumer stalls for 3 cycles after the first result
    task automatic test_back_to_back;
        logic [7:0] v_cw [4];
        logic [7:0] v_cc [4];
        logic [3:0] v_s  [4];
        logic [3:0] v_d  [4];
        logic [1:0] v_f  [4];
        int idx_in, idx_out, stall_left, cyc;
        bit seen;
        v_cw[0] = 8'b10001010; v_s[0] = 4'b1101; v_cc[0] = 8'b10101010; v_d[0] = 4'b1011; v_f[0] = 2'b10;
        v_cw[1] = 8'b10101010; v_s[1] = 4'b0000; v_cc[1] = 8'b10101010; v_d[1] = 4'b1011; v_f[1] = 2'b00;
        v_cw[2] = 8'b10100010; v_s[2] = 4'b0011; v_cc[2] = 8'b10100010; v_d[2] = 4'b1010; v_f[2] = 2'b01;
        v_cw[3] = 8'b00000001; v_s[3] = 4'b1000; v_cc[3] = 8'b00000000; v_d[3] = 4'b0000; v_f[3] = 2'b10;
        idx_in = 0; idx_out = 0; stall_left = 0; cyc = 0; seen = 1'b0;
        while (idx_out < 4 && cyc < 40) begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            in_valid  = (idx_in < 4);
            if (idx_in < 4) begin
                cw = v_cw[idx_in];
                s  = v_s[idx_in];
            end
            #1;
            if (stall_left > 0) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
                n_checks++; if (out_valid !== 1'b1 || cc !== v_cc[idx_out] || data !== v_d[idx_out] || {es, ed} !== v_f[idx_out])
                begin n_fail++; $display("FAIL stall_hold got vld=%b cc=%b d=%b f=%b want 1/%b/%b/%b", out_valid, cc, data, {es, ed}, v_cc[idx_out], v_d[idx_out], v_f[idx_out]); end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                n_checks++; if (cc !== v_cc[idx_out] || data !== v_d[idx_out] || {es, ed} !== v_f[idx_out])
                begin n_fail++; $display("FAIL stream_result_%0d got cc=%b d=%b f=%b want %b/%b/%b", idx_out, cc, data, {es, ed}, v_cc[idx_out], v_d[idx_out], v_f[idx_out]); end
                exp_corr   += int'(v_f[idx_out][1]);
                exp_uncorr += int'(v_f[idx_out][0]);
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (idx_out != 4) begin n_fail++; $display("FAIL stream_timeout got %0d results want 4", idx_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_no_dup got %b want 0", out_valid); end
        n_checks++; if (corr !== 16'(exp_corr) || uncorr !== 16'(exp_uncorr)) begin n_fail++; $display("FAIL stream_counters got %0d/%0d want %0d/%0d", corr, uncorr, exp_corr, exp_uncorr); end
    endtask

    // The 2-bit counter saturates at 3; a clear beats a simultaneous increment
    task automatic test_saturation;
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        exp_corr = 0; exp_uncorr = 0;
        n_checks++; if (corr2 !== 2'd0 || uncorr2 !== 2'd0 || corr !== 16'd0 || uncorr !== 16'd0)
        begin n_fail++; $display("FAIL clear_counters got %0d/%0d %0d/%0d want all 0", corr2, uncorr2, corr, uncorr); end
        in_valid = 1'b1; cw = 8'h01; s = 4'b1000; out_ready = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        repeat (3) step();
        exp_corr = 5;
        n_checks++; if (corr2 !== 2'd3) begin n_fail++; $display("FAIL sat_corr_cnt got %0d want 3", corr2); end
        n_checks++; if (corr !== 16'(exp_corr)) begin n_fail++; $display("FAIL wide_corr_cnt got %0d want %0d", corr, exp_corr); end
        drive_one(8'h01, 4'b1000);
        n_checks++; if (out_valid !== 1'b1 || es !== 1'b1) begin n_fail++; $display("FAIL clear_race_setup got vld=%b es=%b want 1/1", out_valid, es); end
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        exp_corr = 0;
        n_checks++; if (corr2 !== 2'd0 || corr !== 16'd0) begin n_fail++; $display("FAIL clear_wins got %0d/%0d want 0/0", corr2, corr); end
    endtask

    // An asynchronous reset with two pairs in flight discards both
    task automatic test_reset_midflight;
        in_valid = 1'b1; cw = 8'h01; s = 4'b1000; out_ready = 1'b1;
        step();
        cw = 8'h00; s = 4'b1111;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || cc !== 8'h00 || es !== 1'b0) begin n_fail++; $display("FAIL async_rst_out got vld=%b cc=%b es=%b want 0/0/0", out_valid, cc, es); end
        n_checks++; if (corr !== 16'd0 || uncorr !== 16'd0) begin n_fail++; $display("FAIL async_rst_cnt got %0d/%0d want 0/0", corr, uncorr); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready got %b want 1", in_ready); end
        exp_corr = 0; exp_uncorr = 0;
        step();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stale_after_rst cycle %0d got %b want 0", i, out_valid); end
        end
        drive_one(8'b10101010, 4'b0000);
        n_checks++; if (out_valid !== 1'b1 || cc !== 8'b10101010 || {es, ed} !== 2'b00)
        begin n_fail++; $display("FAIL first_after_rst got vld=%b cc=%b f=%b want 1/10101010/00", out_valid, cc, {es, ed}); end
        step();
        n_checks++; if (corr !== 16'd0 || uncorr !== 16'd0) begin n_fail++; $display("FAIL cnt_after_rst got %0d/%0d want 0/0", corr, uncorr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clean();
        test_double();
        test_bit7();
        test_back_to_back();
        test_saturation();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_error_corrector_8bit.md
DEC_ERROR_CORRECTOR_8BIT -- requirements
Module: dec_error_corrector_8bit

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of each error-statistics counter.
REQ-002 SHALL provide clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide in_valid  input  1  codeword/syndrome pair present.
REQ-005 SHALL provide in_ready  output  1  block accepts a pair this cycle.
REQ-006 SHALL provide codeword_with_errors  input  8  received extended-Hamming(8,4) codeword.
REQ-007 SHALL provide syndrome  input  4  syndrome from dec_mat_multiplier_8bit (its mul_result) for the same codeword.
REQ-008 SHALL provide out_valid  output  1  result present.
REQ-009 SHALL provide out_ready  input  1  consumer accepts result.
REQ-010 SHALL provide corrected_codeword  output  8  codeword after correction.
REQ-011 SHALL provide data_out  output  4  decoded data bits.
REQ-012 SHALL provide err_single  output  1  single-bit error corrected in this result.
REQ-013 SHALL provide err_double  output  1  uncorrectable double error in this result.
REQ-014 SHALL provide cnt_clear  input  1  synchronous clear of both counters.
REQ-015 SHALL provide corr_cnt  output  CNT_W  count of delivered err_single results.
REQ-016 SHALL provide uncorr_cnt  output  CNT_W  count of delivered err_double results.

Function
REQ-017 Syndrome decode SHALL be: s[3] = overall-parity mismatch, s[2:0] = bit index k.
REQ-018 s=0000 -> no error, codeword passed unchanged, both flags 0.
REQ-019 s[3]=1, k=0 -> flip cw[0], err_single=1.
REQ-020 s[3]=1, k!=0 -> flip cw[k], err_single=1.
REQ-021 s[3]=0, k!=0 -> codeword passed unchanged, err_double=1, err_single=0.
REQ-022 data_out SHALL be {cc[7], cc[6], cc[5], cc[3]} of corrected_codeword cc.
REQ-023 Datapath SHALL be a 2-stage pipeline: stage 1 registers codeword and decoded class/index; stage 2 registers corrected codeword, data and flags.
REQ-024 Advance enable adv = !out_valid || out_ready; both stages shift only when adv=1; in_ready = adv (combinational).
REQ-025 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-026 Latency with no backpressure SHALL be 2 cycles from input transfer to out_valid=1; throughput 1 per cycle.
REQ-027 While out_valid=1 and out_ready=0, all output data, flags and stage-1 contents SHALL hold stable; no pair is lost or duplicated.
REQ-028 A bubble (in_valid=0 while adv=1) SHALL propagate as an invalid stage; out_valid=0 when stage 2 holds a bubble.
REQ-029 Counters SHALL increment by 1 only on an output transfer carrying the corresponding flag.
REQ-030 Counters SHALL saturate at 2^CNT_W-1; no wrap.
REQ-031 cnt_clear=1 SHALL zero both counters next edge; clear wins over a simultaneous increment.
REQ-032 Output data/flag fields SHALL be don't-care-free: they read 0 whenever out_valid=0 after reset until the first result arrives.

Reset
REQ-033 rst=1 SHALL immediately clear both stage valids, out_valid, corrected_codeword, data_out, err_single, err_double, corr_cnt, uncorr_cnt to 0, regardless of clk.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight pairs; first output after release comes only from pairs accepted after release.
REQ-035 in_ready SHALL read 1 during and immediately after reset (out_valid=0).

Verification
REQ-036 cw=10001010, s=1101, out_ready=1 -> 2 cycles later cc=10101010, data_out=1011, err_single=1, corr_cnt=1.
REQ-037 cw=10101010, s=0000 -> cc=10101010, data_out=1011, flags 0, counters unchanged.
REQ-038 cw=10100010, s=0011 -> cc=10100010, err_double=1, uncorr_cnt increments by 1.
REQ-039 Stream 4 pairs, hold out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, outputs stable, all 4 results delivered in order.
REQ-040 CNT_W=2, deliver 5 single-error results -> corr_cnt stops at 3; cnt_clear with simultaneous single-error transfer -> corr_cnt=0.
REQ-041 Assert rst asynchronously with 2 pairs in flight -> out_valid, counters 0 at once; no stale result appears after release.
